alt_vipitc121_common_line_sequencer: RTL and testbench
======================================================

# alt_vipitc121_common_line_sequencer

Frame/line timing controller for the clocked-video output path. It sequences the colour-plane sample counter: drives its `count_cycle`, `sclr` and `hd_sdn` inputs, counts the `count_sample` pulses it returns, and walks active lines, horizontal blanking and vertical blanking per frame. It also issues the pixel-FIFO read strobe and flags FIFO underflow during active video.

## Interface
Parameters:
- `NUMBER_OF_COLOUR_PLANES`, 3: colour planes per sample.
- `COLOUR_PLANES_ARE_IN_PARALLEL`, 0: 1 means one sample per cycle.
- `LOG2_NUMBER_OF_COLOUR_PLANES`, 2: width of sample-counter tick bus.
- `CNT_WIDTH`, 16: width of all config inputs and internal counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run frames; sampled at frame boundaries.
- `hd_sdn_in` in 1: HD (1) / SD (0) mode request; latched at frame start.
- `h_active_samples` in CNT_WIDTH: samples per active line.
- `h_blank_cycles` in CNT_WIDTH: blanking cycles after each active line.
- `h_line_cycles` in CNT_WIDTH: total cycles per vertical-blanking line.
- `v_active_lines` in CNT_WIDTH: active lines per frame.
- `v_blank_lines` in CNT_WIDTH: blanking lines per frame.
- `count_sample` in 1: from sample counter, end of one full sample.
- `vid_valid` in 1: pixel FIFO has data.
- `count_cycle` out 1: to sample counter.
- `sclr` out 1: to sample counter.
- `hd_sdn` out 1: to sample counter; latched mode.
- `vid_ready` out 1: FIFO read strobe, equal to `count_sample & count_cycle`.
- `sof` out 1: first cycle of frame.
- `sol` out 1: first cycle of each active line.
- `active` out 1: in H_ACTIVE.
- `line_count` out CNT_WIDTH: current active line index, 0-based.
- `busy` out 1: state not IDLE.
- `underflow` out 1: sticky FIFO underflow flag.

## Operation
- States: IDLE, H_ACTIVE, H_BLANK, V_BLANK.
- **Config shadowing:** all config inputs and `hd_sdn_in` are captured into shadow registers on entry to the first H_ACTIVE of each frame. Changes mid-frame have no effect. Zero values of `h_active_samples`, `v_active_lines` and `h_line_cycles` are clamped to 1.
- **IDLE → H_ACTIVE:** when `enable`=1.
- **H_ACTIVE:**
  - `count_cycle`=1 every cycle.
  - `sclr`=1 on the first cycle only, which realigns the sample counter.
  - Sample counter increments on each `count_sample`.
  - On the `count_sample` that completes `h_active_samples`, the next state is H_BLANK. If `h_blank_cycles`=0, it bypasses H_BLANK to the following-state rule below.
- **H_BLANK:** runs for `h_blank_cycles` cycles. Then:
  - If more active lines remain: H_ACTIVE with `line_count`+1.
  - Otherwise: V_BLANK, or frame end if `v_blank_lines`=0.
- **V_BLANK:** runs for `v_blank_lines`×`h_line_cycles` cycles (line counter × cycle counter; no multiplier).
- **Frame end:** go to H_ACTIVE with `sof` if `enable`=1, else IDLE. Dropping `enable` mid-frame completes the frame.
- **H_ACTIVE length:** `h_active_samples` cycles if the latched `hd_sdn`=1, or `NUMBER_OF_COLOUR_PLANES`=1, or planes are parallel. Otherwise `NUMBER_OF_COLOUR_PLANES`×`h_active_samples` cycles, as set by the `count_sample` feedback.
- `hd_sdn` output equals the latched value; it is 0 in IDLE.
- All counters wrap-free: terminal compare on the clamped shadow values.

## Timing
- **Reset:**
  - State is IDLE.
  - All outputs are 0: `count_cycle`, `sclr`, `hd_sdn`, `vid_ready`, `sof`, `sol`, `active`, `line_count`, `busy`, `underflow`.
  - All counters and shadow registers are cleared.
  - Reset mid-frame returns to IDLE on the next edge with no frame completion.
- **Start latency:** `enable` high in IDLE at edge N gives `sof`=`sol`=`sclr`=`count_cycle`=1 in cycle N+1.
- `sof` and `sol` are single-cycle pulses. `sof` implies `sol`.
- Back-to-back frames have no idle gap: the last V_BLANK cycle is followed directly by the `sof` cycle.
- `vid_ready` is combinational from `count_sample`; all other outputs are registered.
- **Underflow and `sof` in the same cycle:** the flag clears, then sets again.

## Configuration
- `ALT_VIPITC121_SEQ_UNDERFLOW_EN` defined: `underflow` is set when `vid_ready`=1 and `vid_valid`=0. It is sticky and cleared on `sof` or `rst`.
- Macro undefined: `vid_valid` is ignored and `underflow` is tied to 0. Sequencing is unchanged.

## Test plan
All scenarios use the defaults (N=3, sequential) unless noted.
- **SD frame:** `h_active_samples`=4, `h_blank_cycles`=2, `v_active_lines`=2, `v_blank_lines`=1, `h_line_cycles`=14, `hd_sdn_in`=0, `enable` held.
  - `active` high for 12 cycles, then low for 2, twice.
  - 14 V_BLANK cycles follow.
  - `sof` repeats every 42 cycles.
  - `vid_ready` pulses 8 times per frame.
- **HD mode:** same config with `hd_sdn_in`=1.
  - H_ACTIVE is 4 cycles.
  - Frame period is 2×6+14=26.
  - `hd_sdn`=1 from `sof`.
- **Zero edges:** `h_blank_cycles`=0 and `v_blank_lines`=0 → `sol` every 12 cycles and `sof` every 24 cycles, with no blank states visited.
- **Mid-frame config change and `enable` drop:** change `h_active_samples` to 8 and drop `enable` on line 0.
  - The current frame keeps length 4 and completes.
  - Then `busy`=0 and all outputs are 0.
- **Reset mid-H_ACTIVE:** assert `rst` one cycle → next cycle all outputs are 0 and the state is IDLE. Re-enable → `sof` one cycle later.
- **Underflow:** with the macro, `vid_valid`=0 on the 2nd `vid_ready` → `underflow`=1 until the next `sof`. Without the macro, `underflow` stays 0.

Source files
------------

// File: rtl/alt_vipitc121_common_line_sequencer.sv
// Line/frame sequencer for the clocked-video output sample counter.
// Optional FIFO underflow detection: define ALT_VIPITC121_SEQ_UNDERFLOW_EN.
module alt_vipitc121_common_line_sequencer #(
  parameter int NUMBER_OF_COLOUR_PLANES       = 3,
  parameter int COLOUR_PLANES_ARE_IN_PARALLEL = 0,
  parameter int LOG2_NUMBER_OF_COLOUR_PLANES  = 2,
  parameter int CNT_WIDTH                     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 hd_sdn_in,
  input  logic [CNT_WIDTH-1:0] h_active_samples,
  input  logic [CNT_WIDTH-1:0] h_blank_cycles,
  input  logic [CNT_WIDTH-1:0] h_line_cycles,
  input  logic [CNT_WIDTH-1:0] v_active_lines,
  input  logic [CNT_WIDTH-1:0] v_blank_lines,
  input  logic                 count_sample,
  input  logic                 vid_valid,
  output logic                 count_cycle,
  output logic                 sclr,
  output logic                 hd_sdn,
  output logic                 vid_ready,
  output logic                 sof,
  output logic                 sol,
  output logic                 active,
  output logic [CNT_WIDTH-1:0] line_count,
  output logic                 busy,
  output logic                 underflow
);

  // When every cycle carries a whole sample, the cycle itself is the sample tick.
  localparam logic ONE_CYCLE_SAMPLES = (COLOUR_PLANES_ARE_IN_PARALLEL != 0) ||
                                       (NUMBER_OF_COLOUR_PLANES == 1) ||
                                       (LOG2_NUMBER_OF_COLOUR_PLANES == 0);
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, H_ACTIVE, H_BLANK, V_BLANK} state_t;

  state_t state_reg, state_next;

  logic [CNT_WIDTH-1:0] h_active_sh_reg, h_blank_sh_reg, h_line_sh_reg;
  logic [CNT_WIDTH-1:0] v_active_sh_reg, v_blank_sh_reg;
  logic                 hd_sh_reg;

  logic [CNT_WIDTH-1:0] sample_cnt_reg, sample_cnt_next;
  logic [CNT_WIDTH-1:0] cyc_cnt_reg, cyc_cnt_next;
  logic [CNT_WIDTH-1:0] vline_cnt_reg, vline_cnt_next;
  logic [CNT_WIDTH-1:0] line_reg, line_next;

  logic count_cycle_reg, sclr_reg, hd_sdn_reg, sof_reg, sol_reg, active_reg, busy_reg;
  logic sof_next, sol_next, sclr_next, load_cfg;
  logic line_done, frame_done, start_frame, sample_tick;

  function automatic logic [CNT_WIDTH-1:0] clamp1(input logic [CNT_WIDTH-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign sample_tick = count_cycle_reg & (ONE_CYCLE_SAMPLES | count_sample);
  assign vid_ready   = count_sample & count_cycle_reg;

  always_comb begin
    state_next      = state_reg;
    sof_next        = 1'b0;
    sol_next        = 1'b0;
    sclr_next       = 1'b0;
    load_cfg        = 1'b0;
    line_done       = 1'b0;
    frame_done      = 1'b0;
    start_frame     = 1'b0;
    line_next       = line_reg;
    sample_cnt_next = sample_cnt_reg;
    cyc_cnt_next    = cyc_cnt_reg;
    vline_cnt_next  = vline_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      H_ACTIVE: begin
        if (sample_tick) begin
          sample_cnt_next = sample_cnt_reg + ONE;
          if (sample_cnt_reg == h_active_sh_reg - ONE) begin
            if (h_blank_sh_reg == '0) line_done  = 1'b1;
            else                      state_next = H_BLANK;
          end
        end
      end
      H_BLANK: begin
        cyc_cnt_next = cyc_cnt_reg + ONE;
        if (cyc_cnt_reg == h_blank_sh_reg - ONE) line_done = 1'b1;
      end
      V_BLANK: begin
        if (cyc_cnt_reg == h_line_sh_reg - ONE) begin
          cyc_cnt_next   = '0;
          vline_cnt_next = vline_cnt_reg + ONE;
          if (vline_cnt_reg == v_blank_sh_reg - ONE) frame_done = 1'b1;
        end else begin
          cyc_cnt_next = cyc_cnt_reg + ONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (line_done) begin
      if (line_reg != v_active_sh_reg - ONE) begin
        state_next = H_ACTIVE;
        sol_next   = 1'b1;
        sclr_next  = 1'b1;
        line_next  = line_reg + ONE;
      end else if (v_blank_sh_reg == '0) begin
        frame_done = 1'b1;
      end else begin
        state_next = V_BLANK;
      end
    end

    // Frame end: a dropped enable lets the frame finish, then parks in IDLE.
    if (frame_done) begin
      if (enable) start_frame = 1'b1;
      else        state_next  = IDLE;
    end

    if (start_frame) begin
      state_next = H_ACTIVE;
      sof_next   = 1'b1;
      sol_next   = 1'b1;
      sclr_next  = 1'b1;
      load_cfg   = 1'b1;
      line_next  = '0;
    end

    if (state_next == IDLE) line_next = '0;

    // Every state entry (and each new line) restarts the per-state counters.
    if (state_next != state_reg || sclr_next) begin
      sample_cnt_next = '0;
      cyc_cnt_next    = '0;
      vline_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      h_active_sh_reg <= '0;
      h_blank_sh_reg  <= '0;
      h_line_sh_reg   <= '0;
      v_active_sh_reg <= '0;
      v_blank_sh_reg  <= '0;
      hd_sh_reg       <= 1'b0;
      sample_cnt_reg  <= '0;
      cyc_cnt_reg     <= '0;
      vline_cnt_reg   <= '0;
      line_reg        <= '0;
      count_cycle_reg <= 1'b0;
      sclr_reg        <= 1'b0;
      hd_sdn_reg      <= 1'b0;
      sof_reg         <= 1'b0;
      sol_reg         <= 1'b0;
      active_reg      <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sample_cnt_reg <= sample_cnt_next;
      cyc_cnt_reg    <= cyc_cnt_next;
      vline_cnt_reg  <= vline_cnt_next;
      line_reg       <= line_next;
      if (load_cfg) begin
        h_active_sh_reg <= clamp1(h_active_samples);
        h_blank_sh_reg  <= h_blank_cycles;
        h_line_sh_reg   <= clamp1(h_line_cycles);
        v_active_sh_reg <= clamp1(v_active_lines);
        v_blank_sh_reg  <= v_blank_lines;
        hd_sh_reg       <= hd_sdn_in;
      end
      count_cycle_reg <= (state_next == H_ACTIVE);
      active_reg      <= (state_next == H_ACTIVE);
      busy_reg        <= (state_next != IDLE);
      sclr_reg        <= sclr_next;
      sof_reg         <= sof_next;
      sol_reg         <= sol_next;
      if (state_next == IDLE) hd_sdn_reg <= 1'b0;
      else if (load_cfg)      hd_sdn_reg <= hd_sdn_in;
      else                    hd_sdn_reg <= hd_sh_reg;
    end
  end

  assign count_cycle = count_cycle_reg;
  assign sclr        = sclr_reg;
  assign hd_sdn      = hd_sdn_reg;
  assign sof         = sof_reg;
  assign sol         = sol_reg;
  assign active      = active_reg;
  assign busy        = busy_reg;
  assign line_count  = line_reg;

`ifdef ALT_VIPITC121_SEQ_UNDERFLOW_EN
  logic underflow_reg;

  // A new underflow in the sof cycle wins over the frame-start clear.
  always_ff @(posedge clk) begin
    if (rst)                         underflow_reg <= 1'b0;
    else if (vid_ready && !vid_valid) underflow_reg <= 1'b1;
    else if (sof_reg)                underflow_reg <= 1'b0;
  end

  assign underflow = underflow_reg;
`else
  logic unused_vid_valid;
  assign unused_vid_valid = vid_valid;
  assign underflow        = 1'b0;
`endif

endmodule

// File: tb/tb_alt_vipitc121_common_line_sequencer.sv
// Directed bench: models the colour-plane sample counter and checks every output cycle by cycle.
module tb_alt_vipitc121_common_line_sequencer;

  localparam int CW = 16;
`ifdef ALT_VIPITC121_SEQ_UNDERFLOW_EN
  localparam logic UF_EN = 1'b1;
`else
  localparam logic UF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, hd_sdn_in;
  logic [CW-1:0] h_active_samples, h_blank_cycles, h_line_cycles, v_active_lines, v_blank_lines;
  logic          count_sample, vid_valid;
  logic          count_cycle, sclr, hd_sdn, vid_ready, sof, sol, active, busy, underflow;
  logic [CW-1:0] line_count;

  int n_checks = 0;
  int n_errors = 0;
  logic uf_mode;

  alt_vipitc121_common_line_sequencer #(
    .NUMBER_OF_COLOUR_PLANES(3),
    .COLOUR_PLANES_ARE_IN_PARALLEL(0),
    .LOG2_NUMBER_OF_COLOUR_PLANES(2),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .hd_sdn_in(hd_sdn_in),
    .h_active_samples(h_active_samples), .h_blank_cycles(h_blank_cycles),
    .h_line_cycles(h_line_cycles), .v_active_lines(v_active_lines),
    .v_blank_lines(v_blank_lines), .count_sample(count_sample), .vid_valid(vid_valid),
    .count_cycle(count_cycle), .sclr(sclr), .hd_sdn(hd_sdn), .vid_ready(vid_ready),
    .sof(sof), .sol(sol), .active(active), .line_count(line_count),
    .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Sample counter: three planes per sample in SD, one per cycle in HD; sclr realigns.
  logic [1:0] sc_cnt = 2'd0;
  logic [1:0] sc_eff;
  assign sc_eff       = sclr ? 2'd0 : sc_cnt;
  assign count_sample = count_cycle & (hd_sdn | (sc_eff == 2'd2));
  always_ff @(posedge clk)
    if (count_cycle) sc_cnt <= (hd_sdn | (sc_eff == 2'd2)) ? 2'd0 : sc_eff + 2'd1;

  // FIFO model: optionally empty on the second read of a frame.
  int vr_cnt = 0;
  always_ff @(posedge clk) begin
    if (sof)            vr_cnt <= vid_ready ? 1 : 0;
    else if (vid_ready) vr_cnt <= vr_cnt + 1;
  end
  assign vid_valid = !(uf_mode && vr_cnt == 1);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] pack_out();
    return {8'd0, line_count, hd_sdn, busy, sof, sol, active, sclr, count_cycle, underflow};
  endfunction

  // Starts on a sof cycle; returns on the cycle right after the frame.
  task automatic run_frame(input string name, input int period, input int line_len,
                           input int act_len, input int lines, input int exp_vr,
                           input logic exp_hd, input int uf_from);
    int vr;
    int k;
    int w;
    logic [CW-1:0] e_line;
    logic e_act, e_sol, e_uf, e_sof;
    vr = 0;
    for (int i = 0; i < period; i++) begin
      k      = i / line_len;
      w      = i % line_len;
      e_act  = (k < lines) && (w < act_len);
      e_sol  = (k < lines) && (w == 0);
      e_sof  = (i == 0);
      e_line = 16'((k < lines) ? k : lines - 1);
      e_uf   = UF_EN && (uf_from >= 0) && (i >= uf_from);
      check_eq($sformatf("%s[%0d]", name, i), pack_out(),
               {8'd0, e_line, exp_hd, 1'b1, e_sof, e_sol, e_act, e_sol, e_act, e_uf});
      if (vid_ready) vr++;
      step(1);
    end
    check_eq({name, "_vid_ready_count"}, 32'(vr), 32'(exp_vr));
    $display("frame %s: period %0d, vid_ready pulses %0d", name, period, vr);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; hd_sdn_in = 1'b0; uf_mode = 1'b0;
    h_active_samples = 16'd4; h_blank_cycles = 16'd2; h_line_cycles = 16'd14;
    v_active_lines = 16'd2; v_blank_lines = 16'd1;
    step(2);
    check_eq("reset_outs", pack_out(), 32'd0);
    check_eq("reset_vid_ready", 32'(vid_ready), 32'd0);
    rst = 1'b0;
    step(1);
    check_eq("idle_outs", pack_out(), 32'd0);

    enable = 1'b1;
    step(1);
    run_frame("sd1", 42, 14, 12, 2, 8, 1'b0, -1);
    hd_sdn_in = 1'b1;
    run_frame("sd2_hd_req_midframe", 42, 14, 12, 2, 8, 1'b0, -1);
    hd_sdn_in = 1'b0; h_blank_cycles = 16'd0; v_blank_lines = 16'd0;
    run_frame("hd", 26, 6, 4, 2, 8, 1'b1, -1);
    h_blank_cycles = 16'd2; v_blank_lines = 16'd1;
    run_frame("zero_blank", 24, 12, 12, 2, 8, 1'b0, -1);
    h_active_samples = 16'd8; enable = 1'b0;
    run_frame("enable_drop", 42, 14, 12, 2, 8, 1'b0, -1);
    check_eq("drop_idle_outs", pack_out(), 32'd0);
    check_eq("drop_idle_vid_ready", 32'(vid_ready), 32'd0);
    step(3);
    check_eq("drop_idle_later", pack_out(), 32'd0);

    h_active_samples = 16'd4; enable = 1'b1;
    step(1);
    check_eq("restart_sof", 32'({sof, sol, sclr, count_cycle}), 32'hF);
    step(3);
    check_eq("pre_reset_active", 32'({active, busy}), 32'h3);
    rst = 1'b1; enable = 1'b0;
    step(1);
    check_eq("mid_reset_outs", pack_out(), 32'd0);
    check_eq("mid_reset_vid_ready", 32'(vid_ready), 32'd0);
    rst = 1'b0;
    step(1);
    check_eq("post_reset_idle", pack_out(), 32'd0);

    enable = 1'b1; uf_mode = 1'b1;
    step(1);
    run_frame("underflow", 42, 14, 12, 2, 8, 1'b0, 6);
    uf_mode = 1'b0;
    check_eq("underflow_at_next_sof", 32'({sof, underflow}), 32'({1'b1, UF_EN}));
    step(1);
    check_eq("underflow_cleared", 32'(underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
